mouse_packet_decoder: RTL and testbench

Parametrised successor to the PS/2 mouse byte decoder. Assembles 3-byte standard or 4-byte wheel packets from the PS/2 receiver's byte stream and validates packet sync with resync on timeout. Accumulates a clamped, sensitivity-scaled cursor position and reports button state, press edges and wheel delta. Sits between the PS/2 receiver and the game/cursor logic.

---
 rtl/mouse_packet_decoder_pkg.sv | 28 ++
 rtl/mouse_packet_decoder_axis.sv | 60 ++++++
 rtl/mouse_packet_decoder.sv | 175 +++++++++++++++++
 tb/tb_mouse_packet_decoder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_packet_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mouse_packet_decoder_pkg
//  Purpose  : Shared packet-FSM encoding and PS/2 status-byte bit positions.
//  Revision : 1.0
// ============================================================================
package mouse_packet_decoder_pkg;

    localparam logic [2:0] ST_B0    = 3'd0;
    localparam logic [2:0] ST_B1    = 3'd1;
    localparam logic [2:0] ST_B2    = 3'd2;
    localparam logic [2:0] ST_B3    = 3'd3;
    localparam logic [2:0] ST_APPLY = 3'd4;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_M = 2;
    localparam int SYNC  = 3;
    localparam int XS    = 4;
    localparam int YS    = 5;
    localparam int XO    = 6;
    localparam int YO    = 7;

    // Raw PS/2 movement delta: sign bit from the status byte plus 8 data bits.
    localparam int DELTA_W = 9;

endpackage
`default_nettype wire

// File: rtl/mouse_packet_decoder_axis.sv
`default_nettype none
// ============================================================================
//  Module   : mouse_axis_accum
//  Purpose  : One cursor axis: scale a raw delta, accumulate, clamp to [0,MAX].
//  Revision : 1.0
// ============================================================================
module mouse_axis_accum
    import mouse_packet_decoder_pkg::*;
#(
    parameter int W      = 10,
    parameter int MAX    = 639,
    parameter int INIT   = 320,
    parameter int SHIFT  = 0,
    parameter int INVERT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               zero,
    input  logic [DELTA_W-1:0] delta,
    output logic [W-1:0]       pos
);

    localparam int AW = W + 2;
    localparam logic signed [AW-1:0] c_max = AW'(MAX);

    logic signed [AW-1:0] w_ext;
    logic signed [AW-1:0] w_shift;
    logic signed [AW-1:0] w_step;
    logic signed [AW-1:0] w_sum;
    logic        [W-1:0]  w_next;

    assign w_ext   = {{(AW-DELTA_W){delta[DELTA_W-1]}}, delta};
    assign w_shift = w_ext >>> SHIFT;

    always_comb begin
        w_step = w_shift;
        if (zero)
            w_step = '0;
        // Y is screen-down positive while PS/2 reports up-positive.
        if (INVERT != 0)
            w_sum = $signed({2'b00, pos}) - w_step;
        else
            w_sum = $signed({2'b00, pos}) + w_step;
        w_next = w_sum[W-1:0];
        if (w_sum < 0)
            w_next = '0;
        else if (w_sum > c_max)
            w_next = c_max[W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pos <= W'(INIT);
        else if (load)
            pos <= w_next;
    end

endmodule
`default_nettype wire

// File: rtl/mouse_packet_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : mouse_packet_decoder
//  Purpose  : Assemble PS/2 mouse packets, resync on timeout, track cursor.
//  Revision : 1.0
// ============================================================================
module mouse_packet_decoder
    import mouse_packet_decoder_pkg::*;
#(
    parameter int WHEEL_MODE = 0,
    parameter int X_W        = 10,
    parameter int Y_W        = 9,
    parameter int X_MAX      = 639,
    parameter int Y_MAX      = 479,
    parameter int X_INIT     = 320,
    parameter int Y_INIT     = 240,
    parameter int SHIFT      = 0,
    parameter int TIMEOUT    = 50000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mouseReady,
    input  logic [7:0]     mouseData,
    output logic           decodeReady,
    output logic [X_W-1:0] mouseX,
    output logic [Y_W-1:0] mouseY,
    output logic [8:0]     mousevx,
    output logic [8:0]     mousevy,
    output logic [2:0]     mousebtn,
    output logic [2:0]     mousepress,
    output logic [3:0]     mousewheel,
    output logic           sync_err
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [2:0]       r_state;
    logic             r_ready_prev;
    logic [TMR_W-1:0] r_timer;
    logic [2:0]       r_btn_new;
    logic             r_xs, r_ys, r_xo, r_yo;
    logic [7:0]       r_xbyte, r_ybyte;
    logic [3:0]       w_wheel;
    logic             w_accept;
    logic             w_apply;
    logic             w_timeout;

    assign w_accept  = mouseReady & ~r_ready_prev;
    assign w_apply   = (r_state == ST_APPLY);
    assign w_timeout = (r_timer == TMR_W'(TIMEOUT - 1));

    generate
        if (WHEEL_MODE != 0) begin : g_wheel
            logic [3:0] r_wheel_nib;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    r_wheel_nib <= '0;
                else if (r_state == ST_B3 && w_accept)
                    r_wheel_nib <= mouseData[3:0];
            end
            assign w_wheel = r_wheel_nib;
        end else begin : g_no_wheel
            assign w_wheel = 4'd0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_B0;
            r_ready_prev <= 1'b0;
            r_timer      <= '0;
            r_btn_new    <= '0;
            r_xs         <= 1'b0;
            r_ys         <= 1'b0;
            r_xo         <= 1'b0;
            r_yo         <= 1'b0;
            r_xbyte      <= '0;
            r_ybyte      <= '0;
            decodeReady  <= 1'b0;
            mousevx      <= '0;
            mousevy      <= '0;
            mousebtn     <= '0;
            mousepress   <= '0;
            mousewheel   <= '0;
            sync_err     <= 1'b0;
        end else begin
            decodeReady <= 1'b0;
            mousepress  <= '0;
            sync_err    <= 1'b0;
            // An edge arriving during APPLY is held so B0 sees it next cycle.
            if (!(w_apply && w_accept))
                r_ready_prev <= mouseReady;

            case (r_state)
                ST_B0: begin
                    r_timer <= '0;
                    if (w_accept) begin
                        if (mouseData[SYNC]) begin
                            r_btn_new <= {mouseData[BTN_M], mouseData[BTN_R], mouseData[BTN_L]};
                            r_xs      <= mouseData[XS];
                            r_ys      <= mouseData[YS];
                            r_xo      <= mouseData[XO];
                            r_yo      <= mouseData[YO];
                            r_state   <= ST_B1;
                        end else begin
                            sync_err <= 1'b1;
                        end
                    end
                end
                ST_B1, ST_B2, ST_B3: begin
                    if (w_accept) begin
                        r_timer <= '0;
                        if (r_state == ST_B1) begin
                            r_xbyte <= mouseData;
                            r_state <= ST_B2;
                        end else if (r_state == ST_B2) begin
                            r_ybyte <= mouseData;
                            r_state <= (WHEEL_MODE != 0) ? ST_B3 : ST_APPLY;
                        end else begin
                            r_state <= ST_APPLY;
                        end
                    end else if (w_timeout) begin
                        r_timer  <= '0;
                        r_state  <= ST_B0;
                        sync_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                ST_APPLY: begin
                    decodeReady <= 1'b1;
                    mousevx     <= {r_xs, r_xbyte};
                    mousevy     <= {r_ys, r_ybyte};
                    mousebtn    <= r_btn_new;
                    mousepress  <= r_btn_new & ~mousebtn;
                    mousewheel  <= w_wheel;
                    r_state     <= ST_B0;
                end
                default: r_state <= ST_B0;
            endcase
        end
    end

    mouse_axis_accum #(
        .W      (X_W),
        .MAX    (X_MAX),
        .INIT   (X_INIT),
        .SHIFT  (SHIFT),
        .INVERT (0)
    ) u_axis_x (
        .clk    (clk),
        .rst    (rst),
        .load   (w_apply),
        .zero   (r_xo),
        .delta  ({r_xs, r_xbyte}),
        .pos    (mouseX)
    );

    mouse_axis_accum #(
        .W      (Y_W),
        .MAX    (Y_MAX),
        .INIT   (Y_INIT),
        .SHIFT  (SHIFT),
        .INVERT (1)
    ) u_axis_y (
        .clk    (clk),
        .rst    (rst),
        .load   (w_apply),
        .zero   (r_yo),
        .delta  ({r_ys, r_ybyte}),
        .pos    (mouseY)
    );

endmodule
`default_nettype wire

// File: tb/tb_mouse_packet_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mouse_packet_decoder
//  Purpose  : Two decoder configurations checked cycle-by-cycle against a model.
//  Revision : 1.0
// ============================================================================
module tb_mouse_packet_decoder;

    localparam int TMO = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ready0 = 1'b0, ready1 = 1'b0;
    logic [7:0] data0 = '0, data1 = '0;

    logic       dr0, dr1, se0, se1;
    logic [9:0] x0, x1;
    logic [8:0] y0, y1, vx0, vx1, vy0, vy1;
    logic [2:0] btn0, btn1, pr0, pr1;
    logic [3:0] wh0, wh1;

    int vectors = 0;
    int misc    = 0;
    bit chk_en  = 0;
    int serr_cnt[2] = '{0, 0};
    int press_cnt1  = 0;

    always #5 clk = ~clk;

    mouse_packet_decoder #(.WHEEL_MODE(0), .SHIFT(0), .TIMEOUT(TMO)) dut0 (
        .clk(clk), .rst(rst), .mouseReady(ready0), .mouseData(data0),
        .decodeReady(dr0), .mouseX(x0), .mouseY(y0), .mousevx(vx0), .mousevy(vy0),
        .mousebtn(btn0), .mousepress(pr0), .mousewheel(wh0), .sync_err(se0));

    mouse_packet_decoder #(.WHEEL_MODE(1), .SHIFT(1), .TIMEOUT(TMO)) dut1 (
        .clk(clk), .rst(rst), .mouseReady(ready1), .mouseData(data1),
        .decodeReady(dr1), .mouseX(x1), .mouseY(y1), .mousevx(vx1), .mousevy(vy1),
        .mousebtn(btn1), .mousepress(pr1), .mousewheel(wh1), .sync_err(se1));

    // ---------------- behavioural model (index 0 = 3-byte/no shift, 1 = wheel/shift 1)
    int         c_need[2]  = '{3, 4};
    int         c_shift[2] = '{0, 1};
    logic [7:0] m_pkt [2][4];
    int         m_n[2], m_idle[2], m_x[2], m_y[2];
    bit         m_prev[2], m_app[2];
    logic [8:0] e_vx[2], e_vy[2];
    logic [2:0] e_btn[2], e_press[2];
    logic [3:0] e_wheel[2];
    logic       e_dr[2], e_serr[2];

    function automatic int floor_shift(int v, int s);
        int dv;
        dv = 1 << s;
        if (v >= 0) return v / dv;
        return -((-v + dv - 1) / dv);
    endfunction

    function automatic int clampi(int v, int hi);
        if (v < 0)  return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic m_reset(int d);
        m_n[d] = 0; m_idle[d] = 0; m_prev[d] = 0; m_app[d] = 0;
        m_x[d] = 320; m_y[d] = 240;
        e_vx[d] = '0; e_vy[d] = '0; e_btn[d] = '0; e_press[d] = '0;
        e_wheel[d] = '0; e_dr[d] = 0; e_serr[d] = 0;
    endtask

    task automatic m_apply(int d);
        logic [7:0] st;
        int vx, vy, dx, dy;
        st = m_pkt[d][0];
        vx = st[4] ? int'(m_pkt[d][1]) - 256 : int'(m_pkt[d][1]);
        vy = st[5] ? int'(m_pkt[d][2]) - 256 : int'(m_pkt[d][2]);
        dx = st[6] ? 0 : floor_shift(vx, c_shift[d]);
        dy = st[7] ? 0 : floor_shift(vy, c_shift[d]);
        m_x[d]     = clampi(m_x[d] + dx, 639);
        m_y[d]     = clampi(m_y[d] - dy, 479);
        e_vx[d]    = {st[4], m_pkt[d][1]};
        e_vy[d]    = {st[5], m_pkt[d][2]};
        e_press[d] = st[2:0] & ~e_btn[d];
        e_btn[d]   = st[2:0];
        e_wheel[d] = (c_need[d] == 4) ? m_pkt[d][3][3:0] : 4'd0;
        e_dr[d]    = 1;
    endtask

    task automatic m_step(int d, logic r, logic [7:0] b);
        bit acc;
        acc = r && !m_prev[d];
        e_dr[d] = 0; e_press[d] = '0; e_serr[d] = 0;
        if (m_app[d]) begin
            m_apply(d);
            m_app[d] = 0;
            if (!acc) m_prev[d] = r;
            return;
        end
        m_prev[d] = r;
        if (m_n[d] == 0) begin
            m_idle[d] = 0;
            if (acc) begin
                if (b[3]) begin m_pkt[d][0] = b; m_n[d] = 1; end
                else e_serr[d] = 1;
            end
        end else if (acc) begin
            m_pkt[d][m_n[d]] = b;
            m_n[d]++;
            m_idle[d] = 0;
            if (m_n[d] == c_need[d]) begin m_app[d] = 1; m_n[d] = 0; end
        end else begin
            m_idle[d]++;
            if (m_idle[d] == TMO) begin m_n[d] = 0; m_idle[d] = 0; e_serr[d] = 1; end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_reset(0);
            m_reset(1);
        end else begin
            m_step(0, ready0, data0);
            m_step(1, ready1, data1);
        end
    end

    // ---------------- comparison
    function automatic logic [48:0] exp_bundle(int d);
        return {e_dr[d], 10'(m_x[d]), 9'(m_y[d]), e_vx[d], e_vy[d],
                e_btn[d], e_press[d], e_wheel[d], e_serr[d]};
    endfunction

    task automatic cmp(int d, logic [48:0] act);
        logic [48:0] ex;
        ex = exp_bundle(d);
        vectors++;
        if (act !== ex) begin
            misc++;
            $display("FAIL cycle_cmp dut%0d t=%0t actual=%h required=%h", d, $time, act, ex);
        end
    endtask

    task automatic lit(string name, int act, int ex);
        vectors++;
        if (act != ex) begin
            misc++;
            $display("FAIL %s actual=%0d required=%0d", name, act, ex);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, {dr0, x0, y0, vx0, vy0, btn0, pr0, wh0, se0});
            cmp(1, {dr1, x1, y1, vx1, vy1, btn1, pr1, wh1, se1});
            if (se0) serr_cnt[0]++;
            if (se1) serr_cnt[1]++;
            if (pr1[0]) press_cnt1++;
        end
    end

    // ---------------- stimulus
    task automatic send(int d, logic [7:0] b, int hi = 3, int lo = 3);
        @(posedge clk); #1;
        if (d == 0) begin data0 = b; ready0 = 1'b1; end
        else        begin data1 = b; ready1 = 1'b1; end
        repeat (hi) @(posedge clk);
        #1;
        if (d == 0) ready0 = 1'b0; else ready1 = 1'b0;
        repeat (lo) @(posedge clk);
    endtask

    task automatic pkt(int d, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2);
        send(d, b0); send(d, b1); send(d, b2);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2 rst = 1'b0;
        #1;
        lit("rst_x0", int'(x0), 320);
        lit("rst_y1", int'(y1), 240);
        lit("rst_wheel1", int'(wh1), 0);
        lit("rst_btn1", int'(btn1), 0);
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic rnd_stream(int d, int n);
        for (int i = 0; i < n; i++) begin
            int lo;
            lo = ($urandom_range(0, 19) == 0) ? TMO + 5 : int'($urandom_range(1, 4));
            send(d, 8'($urandom), int'($urandom_range(1, 4)), lo);
        end
    endtask

    initial begin
        int s;
        #2 rst = 1'b0;
        #1 chk_en = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        lit("reset_x", int'(x0), 320);
        lit("reset_y", int'(y0), 240);

        // basic packet
        pkt(0, 8'h08, 8'h05, 8'h0A);
        lit("basic_x", int'(x0), 325);
        lit("basic_y", int'(y0), 230);
        lit("basic_vx", int'(vx0), 5);
        lit("basic_vy", int'(vy0), 10);

        // sync reject then button-only packet
        s = serr_cnt[0];
        send(0, 8'h21);
        lit("reject_serr", serr_cnt[0] - s, 1);
        pkt(0, 8'h09, 8'h00, 8'h00);
        lit("btn_left", int'(btn0), 1);
        lit("btn_x_same", int'(x0), 325);

        // clamp low X, high Y
        pkt(0, 8'h18, 8'h00, 8'h00);
        pkt(0, 8'h18, 8'hBD, 8'h00);
        lit("pre_clamp_x", int'(x0), 2);
        pkt(0, 8'h18, 8'hF0, 8'h00);
        lit("clamp_x0", int'(x0), 0);
        pkt(0, 8'h28, 8'h00, 8'h10);
        lit("pre_clamp_y", int'(y0), 470);
        pkt(0, 8'h28, 8'h00, 8'hE0);
        lit("clamp_ymax", int'(y0), 479);

        // timeout resync
        pulse_reset();
        s = serr_cnt[0];
        send(0, 8'h08); send(0, 8'h05);
        repeat (TMO + 5) @(posedge clk);
        lit("timeout_serr", serr_cnt[0] - s, 1);
        pkt(0, 8'h08, 8'h01, 8'h01);
        lit("resync_x", int'(x0), 321);
        lit("resync_y", int'(y0), 239);

        // wheel / shift configuration
        pkt(1, 8'h48, 8'hFF, 8'h04); send(1, 8'h00);
        lit("ovf_x", int'(x1), 320);
        lit("shift_y", int'(y1), 238);
        s = press_cnt1;
        pkt(1, 8'h09, 8'h00, 8'h00); send(1, 8'h00);
        pkt(1, 8'h09, 8'h00, 8'h00); send(1, 8'h00);
        lit("press_once", press_cnt1 - s, 1);
        lit("btn_held", int'(btn1), 1);
        pkt(1, 8'h08, 8'h00, 8'h00); send(1, 8'h0F);
        lit("wheel_neg1", int'(wh1), 15);
        send(1, 8'h08); send(1, 8'h02);
        pulse_reset();
        pkt(1, 8'h08, 8'h02, 8'h02); send(1, 8'h01);
        lit("post_rst_x", int'(x1), 321);
        lit("post_rst_y", int'(y1), 239);
        lit("post_rst_wheel", int'(wh1), 1);

        // randomized streams on both configurations
        fork
            rnd_stream(0, 200);
            rnd_stream(1, 200);
        join
        repeat (5) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
`default_nettype wire
